// File: rtl/inertial_integrator_cal_pkg.sv
// Shared types, default widths/constants and the saturating clamp for the
// calibrated pitch integrator.
package inertial_pkg;

  typedef enum logic [1:0] {CAL, RUN} integ_state_t;

  localparam int unsigned DEF_RT_W        = 16;
  localparam int unsigned DEF_INT_W       = 27;
  localparam int unsigned DEF_CAL_LOG2    = 8;
  localparam int unsigned DEF_FUSION_STEP = 1024;
  localparam int          DEF_AZ_GAIN     = 377;
  localparam int unsigned DEF_AZ_SHIFT    = 13;

  // Clamp a signed value to the range of a w-bit signed register.
  function automatic logic signed [63:0] sat_int(input logic signed [63:0] v,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_int = hi;
    else if (v < lo) sat_int = lo;
    else             sat_int = v;
  endfunction

endpackage

// File: rtl/inertial_integrator_cal_if.sv
// Sensor-side sample bus and fused-pitch result of the integrator.
interface inertial_integrator_cal_if
  import inertial_pkg::*;
#(
  parameter int unsigned RT_W = DEF_RT_W
) ();

  logic                   vld;
  logic signed [RT_W-1:0] ptch_rt;
  logic signed [RT_W-1:0] AZ;
  logic                   cal_start;
  logic                   fuse_en;
  logic signed [RT_W-1:0] ptch;
  logic                   ptch_vld;
  logic                   cal_done;

  modport master (output vld, ptch_rt, AZ, cal_start, fuse_en,
                  input  ptch, ptch_vld, cal_done);

  modport slave  (input  vld, ptch_rt, AZ, cal_start, fuse_en,
                  output ptch, ptch_vld, cal_done);

endinterface

// File: rtl/inertial_integrator_cal_offset_cal.sv
// Averages 2^CAL_LOG2 samples of rate and AZ into offsets; done_c marks the
// sample that completes the average.
module offset_cal
  import inertial_pkg::*;
#(
  parameter int unsigned RT_W     = DEF_RT_W,
  parameter int unsigned CAL_LOG2 = DEF_CAL_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   smp,
  input  logic signed [RT_W-1:0] ptch_rt,
  input  logic signed [RT_W-1:0] az,
  output logic signed [RT_W-1:0] rt_off,
  output logic signed [RT_W-1:0] az_off,
  output logic                   done_c
);

  localparam int unsigned SW    = RT_W + CAL_LOG2;
  localparam int unsigned CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** CAL_LOG2);

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic signed [SW-1:0] sum_rt;
  logic signed [SW-1:0] sum_az;
  logic signed [SW-1:0] sum_rt_nx;
  logic signed [SW-1:0] sum_az_nx;

  always_comb begin
    cnt_nx    = cnt + CNT_W'(1);
    sum_rt_nx = sum_rt + SW'(ptch_rt);
    sum_az_nx = sum_az + SW'(az);
    done_c    = smp && (cnt_nx == CNT_FULL);
  end

  // Offsets survive a restart so RUN keeps its last good calibration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sum_rt <= '0;
      sum_az <= '0;
      rt_off <= '0;
      az_off <= '0;
    end else if (clr) begin
      cnt    <= '0;
      sum_rt <= '0;
      sum_az <= '0;
    end else if (done_c) begin
      cnt    <= '0;
      sum_rt <= '0;
      sum_az <= '0;
      rt_off <= RT_W'(sum_rt_nx >>> CAL_LOG2);
      az_off <= RT_W'(sum_az_nx >>> CAL_LOG2);
    end else if (smp) begin
      cnt    <= cnt_nx;
      sum_rt <= sum_rt_nx;
      sum_az <= sum_az_nx;
    end
  end

endmodule

// File: rtl/inertial_integrator_cal.sv
// Offset-compensated gyro integrator with leaky accelerometer fusion,
// saturating accumulator and on-chip offset calibration.
module inertial_integrator_cal
  import inertial_pkg::*;
#(
  parameter int unsigned RT_W        = DEF_RT_W,
  parameter int unsigned INT_W       = DEF_INT_W,
  parameter int unsigned CAL_LOG2    = DEF_CAL_LOG2,
  parameter int unsigned FUSION_STEP = DEF_FUSION_STEP,
  parameter int          AZ_GAIN     = DEF_AZ_GAIN,
  parameter int unsigned AZ_SHIFT    = DEF_AZ_SHIFT
) (
  input logic                 clk,
  input logic                 rst,
  inertial_integrator_cal_if.slave bus
);

  localparam int unsigned CW     = RT_W + 1;
  localparam int unsigned PROD_W = CW + 32;
  localparam int unsigned SUM_W  = INT_W + 2;
  localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(FUSION_STEP);

  integ_state_t             state;
  integ_state_t             state_nx;
  logic signed [RT_W-1:0]   rt_off;
  logic signed [RT_W-1:0]   az_off;
  logic                     cal_fin;
  logic                     smp_cal;
  logic                     smp_run;
  logic signed [INT_W-1:0]  ptch_int;
  logic signed [RT_W-1:0]   ptch_cur;
  logic signed [CW-1:0]     rt_comp;
  logic signed [CW-1:0]     az_comp;
  logic signed [PROD_W-1:0] acc_prod;
  logic signed [CW-1:0]     ptch_acc;
  logic signed [SUM_W-1:0]  fuse;
  logic signed [SUM_W-1:0]  sum;
  logic signed [INT_W-1:0]  sum_sat;

  // A same-cycle cal_start discards the sample in either state.
  assign smp_cal = bus.vld && !bus.cal_start && (state == CAL);
  assign smp_run = bus.vld && !bus.cal_start && (state == RUN);

  offset_cal #(
    .RT_W     (RT_W),
    .CAL_LOG2 (CAL_LOG2)
  ) u_cal (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.cal_start),
    .smp     (smp_cal),
    .ptch_rt (bus.ptch_rt),
    .az      (bus.AZ),
    .rt_off  (rt_off),
    .az_off  (az_off),
    .done_c  (cal_fin)
  );

  always_comb begin
    state_nx = state;
    if (bus.cal_start)                state_nx = CAL;
    else if (state == CAL && cal_fin) state_nx = RUN;
  end

  // Fusion compares against the pitch currently on the output.
  always_comb begin
    ptch_cur = $signed(ptch_int[INT_W-1 -: RT_W]);
    rt_comp  = CW'(bus.ptch_rt) - CW'(rt_off);
    az_comp  = CW'(bus.AZ) - CW'(az_off);
    acc_prod = PROD_W'(az_comp) * PROD_W'(AZ_GAIN);
    ptch_acc = CW'(acc_prod >>> AZ_SHIFT);
    fuse     = '0;
    if (bus.fuse_en) fuse = (ptch_acc > CW'(ptch_cur)) ? STEP_S : -STEP_S;
    sum      = SUM_W'(ptch_int) - SUM_W'(rt_comp) + fuse;
    sum_sat  = INT_W'(sat_int(64'(sum), INT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CAL;
      ptch_int     <= '0;
      bus.ptch_vld <= 1'b0;
      bus.cal_done <= 1'b0;
    end else begin
      state        <= state_nx;
      bus.ptch_vld <= smp_run;
      bus.cal_done <= (state_nx == RUN);
      if (bus.cal_start || (state == CAL && cal_fin)) ptch_int <= '0;
      else if (smp_run)                               ptch_int <= sum_sat;
    end
  end

  assign bus.ptch = ptch_int[INT_W-1 -: RT_W];

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Randomized and directed bench for inertial_integrator_cal against an
// integer-arithmetic reference model of the integrator.
module tb_inertial_integrator_cal;

  localparam int unsigned RT_W     = 16;
  localparam int unsigned INT_W    = 27;
  localparam int unsigned CAL_LOG2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inertial_integrator_cal_if #(.RT_W(RT_W)) bus ();

  inertial_integrator_cal #(
    .RT_W        (RT_W),
    .INT_W       (INT_W),
    .CAL_LOG2    (CAL_LOG2),
    .FUSION_STEP (1024),
    .AZ_GAIN     (377),
    .AZ_SHIFT    (13)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit     m_run;
  int     m_cnt;
  longint m_srt, m_saz, m_rt_off, m_az_off, m_pint;
  bit     m_pvld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (INT_W - 1)) - 1;
    lo = -(longint'(1) <<< (INT_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_srt = 0; m_saz = 0;
    m_rt_off = 0; m_az_off = 0; m_pint = 0; m_pvld = 0;
  endtask

  task automatic model_step(input bit v, input longint rt, input longint az,
                            input bit cs, input bit fe);
    longint rt_comp, az_comp, pacc, pold, f;
    m_pvld = 0;
    if (cs) begin
      m_run = 0; m_cnt = 0; m_srt = 0; m_saz = 0; m_pint = 0;
    end else if (v && !m_run) begin
      m_srt += rt; m_saz += az; m_cnt++;
      if (m_cnt == (1 << CAL_LOG2)) begin
        m_rt_off = m_srt >>> CAL_LOG2;
        m_az_off = m_saz >>> CAL_LOG2;
        m_srt = 0; m_saz = 0; m_cnt = 0;
        m_pint = 0; m_run = 1;
      end
    end else if (v && m_run) begin
      rt_comp = rt - m_rt_off;
      az_comp = az - m_az_off;
      pacc    = (az_comp * 377) >>> 13;
      pold    = m_pint >>> (INT_W - RT_W);
      f       = fe ? ((pacc > pold) ? 1024 : -1024) : 0;
      m_pint  = clamp(m_pint - rt_comp + f);
      m_pvld  = 1;
    end
  endtask

  task automatic cycle(input bit v, input logic [15:0] rt, input logic [15:0] az,
                       input bit cs, input bit fe);
    logic [15:0] ptch_exp;
    @(negedge clk);
    bus.vld = v; bus.ptch_rt = rt; bus.AZ = az; bus.cal_start = cs; bus.fuse_en = fe;
    @(posedge clk);
    model_step(v, longint'($signed(rt)), longint'($signed(az)), cs, fe);
    #1;
    ptch_exp = 16'(m_pint >>> (INT_W - RT_W));
    check("ptch", 64'(bus.ptch[15:0]), 64'(ptch_exp));
    check("ptch_vld", 64'(bus.ptch_vld), 64'(m_pvld));
    check("cal_done", 64'(bus.cal_done), 64'(m_run));
  endtask

  task automatic calibrate(input logic [15:0] rt, input logic [15:0] az);
    for (int i = 0; i < (1 << CAL_LOG2); i++) begin
      cycle(1'b1, rt, az, 1'b0, 1'b0);
      if (i != (1 << CAL_LOG2) - 1) check("cal_busy", 64'(bus.cal_done), 64'd0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int pulses;
    bus.vld = 0; bus.ptch_rt = '0; bus.AZ = '0; bus.cal_start = 0; bus.fuse_en = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ptch", 64'(bus.ptch[15:0]), 64'd0);
    check("rst_ptch_vld", 64'(bus.ptch_vld), 64'd0);
    check("rst_cal_done", 64'(bus.cal_done), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Calibration to rt_off=0x50, az_off=0xA0
    calibrate(16'h0050, 16'h00A0);
    check("cal_done_after", 64'(bus.cal_done), 64'd1);

    // Zero drift
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h0050, 16'h00A0, 1'b0, 1'b0);
      pulses += int'(bus.ptch_vld);
    end
    check("drift_pulses", 64'(pulses), 64'd10);
    check("drift_ptch", 64'(bus.ptch[15:0]), 64'h0000);

    // Gyro integration of rt_comp=2048
    cycle(1'b1, 16'h0850, 16'h00A0, 1'b0, 1'b0);
    check("gyro_ptch", 64'(bus.ptch[15:0]), 64'hFFFF);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Fresh calibration, then fusion +1024 per sample
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    calibrate(16'h0050, 16'h00A0);
    cycle(1'b1, 16'h0050, 16'h10A0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0050, 16'h10A0, 1'b0, 1'b1);
    check("fuse_ptch", 64'(bus.ptch[15:0]), 64'h0001);

    // cal_start collides with vld: sample dropped, back to CAL
    cycle(1'b1, 16'h1234, 16'h0000, 1'b1, 1'b1);
    check("collide_ptch", 64'(bus.ptch[15:0]), 64'h0000);
    check("collide_done", 64'(bus.cal_done), 64'd0);
    check("collide_vld", 64'(bus.ptch_vld), 64'd0);
    calibrate(16'h0100, 16'h0020);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0100, 16'h0020, 1'b0, 1'b0);
    check("recal_ptch", 64'(bus.ptch[15:0]), 64'h0000);

    // Positive saturation
    for (int i = 0; i < 2100; i++) cycle(1'b1, 16'h8000, 16'h0020, 1'b0, 1'b0);
    check("sat_ptch", 64'(bus.ptch[15:0]), 64'h7FFF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)));
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
